// File: rtl/rr_encoder_32x5.sv
// 32-line request encoder with one registered output slot (valid + 5-bit index).
// Latency: req to out_valid/out_index is 1 cycle. grant is combinational in the accept cycle.
// Backpressure: the slot holds while out_valid && !out_ready. It reloads on an accept or when empty.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - asynchronous active-low reset (clears slot and pointer)
//   en         - capture enable for loading a new request into the slot
//   req[31:0]  - level request lines, bit i = requester i
//   out_ready  - consumer accepts out_index this cycle
//   out_valid  - slot holds a valid index
//   out_index  - binary index of the selected requester
//   grant      - onehot(out_index) during an accept cycle, else zero
//
// Build option: RR_ENCODER_ROUND_ROBIN_EN selects round-robin arbitration.
// When it is undefined, arbitration is fixed priority and the lowest set index wins.
module rr_encoder_32x5 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [31:0] req,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_index,
  output logic [31:0] grant
);

  logic        accept;
  logic        loadable;
  logic [4:0]  start;
  logic [62:0] req_dbl;
  logic [31:0] req_rot;
  logic [4:0]  offset;
  logic [4:0]  sel_index;

  assign accept   = out_valid & out_ready;
  assign loadable = ~out_valid | accept;

`ifdef RR_ENCODER_ROUND_ROBIN_EN
  logic [4:0] ptr;

  // On an accept edge the reload search already starts past the requester
  // just granted. That requester then has the lowest priority. The 5-bit add wraps 31 to 0.
  assign start = accept ? (out_index + 5'd1) : ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 5'd0;
    end else if (accept) begin
      ptr <= out_index + 5'd1;
    end
  end
`else
  assign start = 5'd0;
`endif

  // Rotate req so that bit 'start' lands at position 0.
  // The lowest set bit of the rotated vector is then the first requester at or after 'start'.
  assign req_dbl = {req[30:0], req};
  assign req_rot = req_dbl[start +: 32];

  always_comb begin
    offset = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = 5'(i);
      end
    end
  end

  assign sel_index = start + offset;

  // Output slot. When the slot is not loadable, the index is frozen even if req or en change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_index <= 5'd0;
    end else if (loadable) begin
      if (en && (req != 32'd0)) begin
        out_valid <= 1'b1;
        out_index <= sel_index;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign grant = accept ? (32'd1 << out_index) : 32'd0;

endmodule

// File: tb/tb_rr_encoder_32x5.sv
module tb_rr_encoder_32x5;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [31:0] req;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_index;
  logic [31:0] grant;

  int vectors = 0;
  int errors  = 0;

  rr_encoder_32x5 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_index (out_index),
    .grant     (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one slot, search ascending from a start point with wrap.
  logic       mv = 1'b0;
  logic [4:0] mi = 5'd0;
  int         mp = 0;

  function automatic int first_from(input logic [31:0] r, input int s);
    for (int k = 0; k < 32; k++) begin
      if (r[(s + k) % 32]) return (s + k) % 32;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int s;
    int w;
    bit acc;
    if (!reset_n) begin
      mv = 1'b0;
      mi = 5'd0;
      mp = 0;
    end else begin
      acc = mv && out_ready;
      if (!mv || acc) begin
`ifdef RR_ENCODER_ROUND_ROBIN_EN
        s = acc ? (int'(mi) + 1) % 32 : mp;
`else
        s = 0;
`endif
        w = first_from(req, s);
        if (acc) mp = (int'(mi) + 1) % 32;
        if (en && w >= 0) begin
          mv = 1'b1;
          mi = 5'(w);
        end else begin
          mv = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(mv));
    check("out_index", 32'(out_index), 32'(mi));
    check("grant", grant, (mv && out_ready) ? (32'd1 << mi) : 32'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n   = 1'b0;
    en        = 1'b0;
    req       = 32'd0;
    out_ready = 1'b0;
    #22;
    reset_n = 1'b1;

    // Idle requests never produce a valid index or a grant.
    en = 1'b1; req = 32'd0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_grant", grant, 32'd0);
    end

    // Index is held under backpressure even after req drops; a single grant follows.
    out_ready = 1'b0; req = 32'h0000_0010;
    cyc();
    check("hold_load_valid", 32'(out_valid), 32'd1);
    check("hold_load_index", 32'(out_index), 32'd4);
    req = 32'd0;
    cyc();
    check("hold_index_c2", 32'(out_index), 32'd4);
    cyc();
    check("hold_index_c3", 32'(out_index), 32'd4);
    check("hold_no_grant", grant, 32'd0);
    out_ready = 1'b1;
    #1;
    check("hold_grant", grant, 32'h0000_0010);
    cyc();
    check("hold_after_valid", 32'(out_valid), 32'd0);
    check("hold_after_grant", grant, 32'd0);

    // With en low nothing loads. With en high the search begins at the pointer.
    en = 1'b0; req = 32'hFFFF_FFFF; out_ready = 1'b0;
    cyc();
    cyc();
    check("en0_valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    cyc();
    check("en1_valid", 32'(out_valid), 32'd1);
`ifdef RR_ENCODER_ROUND_ROBIN_EN
    check("en1_index_ptr", 32'(out_index), 32'd5);
`else
    check("en1_index_ptr", 32'(out_index), 32'd0);
`endif
    req = 32'h0000_0080; out_ready = 1'b1;
    cyc();
    check("idx7_valid", 32'(out_valid), 32'd1);
    check("idx7_index", 32'(out_index), 32'd7);
    out_ready = 1'b0;

    // A mid-cycle reset clears the slot at once, without waiting for a clock edge.
    #1 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_index", 32'(out_index), 32'd0);
    check("arst_grant", grant, 32'd0);
    #3 reset_n = 1'b1;
    req = 32'h0000_0080; en = 1'b1;
    cyc();
    check("post_rst_index", 32'(out_index), 32'd7);
    check("post_rst_valid", 32'(out_valid), 32'd1);

`ifdef RR_ENCODER_ROUND_ROBIN_EN
    #1 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    req = 32'h8000_0001; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("rr_alt_index", 32'(out_index), (i % 2 == 0) ? 32'd0 : 32'd31);
      check("rr_alt_grant", grant, (i % 2 == 0) ? 32'h0000_0001 : 32'h8000_0000);
    end
`else
    req = 32'h0000_0006; out_ready = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("fixed_index", 32'(out_index), 32'd1);
      check("fixed_grant", grant, 32'h0000_0002);
    end
`endif

    // Random traffic with occasional asynchronous reset pulses.
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: req = 32'd0;
        1: req = 32'd1 << $urandom_range(0, 31);
        2: req = $urandom;
        3: req = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
        default: req = $urandom & $urandom & $urandom;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rr_encoder_32x5.md
RR_ENCODER_32X5 -- requirements
Module: rr_encoder_32x5

Interface
REQ-001 Parameters: none; widths fixed at 32 request lines and a 5-bit index.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  capture enable; when 0, no new request is loaded into the output slot.
REQ-005 req  input  32  level request lines, bit i = requester i.
REQ-006 out_ready  input  1  consumer accepts out_index this cycle.
REQ-007 out_valid  output  1  output slot holds a valid encoded index.
REQ-008 out_index  output  5  binary index of the selected requester.
REQ-009 grant  output  32  one-hot acknowledge to the selected requester, active only in the accept cycle.

Function
REQ-010 The block SHALL hold one registered output slot (valid bit plus 5-bit index); there is no other buffering.
REQ-011 Accept SHALL be defined as out_valid=1 and out_ready=1 in the same cycle.
REQ-012 grant SHALL be combinational: onehot(out_index) during an accept cycle, otherwise all zeros.
REQ-013 The slot SHALL be loadable at an edge when out_valid=0 or an accept occurs.
REQ-014 On a loadable edge with en=1 and req!=0, the slot SHALL load the selected index and set out_valid=1; latency from req to out_valid is exactly 1 cycle.
REQ-015 On a loadable edge with en=0 or req=0, out_valid SHALL become 0; out_index holds its previous value.
REQ-016 Back-to-back accepts SHALL be supported: out_valid can stay 1 across consecutive accept cycles with a new index each cycle.
REQ-017 While out_valid=1 and out_ready=0, out_index SHALL stay stable regardless of req or en changes, including deassertion of the selected req bit.
REQ-018 Selection with round-robin enabled: search starts at pointer ptr (5 bits), ascending with wrap 31->0; the first set req bit wins.
REQ-019 On each accept, ptr SHALL update to (out_index+1) mod 32; 31 wraps to 0.
REQ-020 ptr SHALL NOT change on load without accept or on idle cycles.
REQ-021 The selection used on an accept edge SHALL use the already-updated search start (out_index+1), so the just-granted requester has lowest priority for the reload.
REQ-022 Requesters are responsible for dropping req after grant; the block does not mask held requests.

Reset
REQ-023 reset_n=0 SHALL asynchronously force out_valid=0, out_index=0 and ptr=0; grant is therefore 0.
REQ-024 Reset asserted mid-handshake SHALL discard the slot contents; no grant is issued for the discarded index.
REQ-025 The first load after reset_n rises SHALL occur at the first rising edge that satisfies REQ-014.

Configuration
REQ-026 Macro RR_ENCODER_ROUND_ROBIN_EN: when defined, selection follows REQ-018..REQ-021.
REQ-027 Without RR_ENCODER_ROUND_ROBIN_EN, ptr SHALL not exist and selection SHALL be fixed priority, with the lowest set index winning; all other requirements are unchanged.

Verification
REQ-028 Reset, then req=0x0000_0000 with en=1 for 5 cycles -> out_valid=0 and grant=0 throughout.
REQ-029 req=0x8000_0001, out_ready=1, ROUND_ROBIN_EN defined -> indices 0, 31, 0, 31 on consecutive cycles; grant=0x1, 0x8000_0000 alternating.
REQ-030 req=0x0000_0010, out_ready=0 for 3 cycles, req dropped to 0 in cycle 2, then out_ready=1 -> out_index=4 held throughout; single grant=0x10; out_valid=0 the next cycle.
REQ-031 en=0 with req=0xFFFF_FFFF -> out_valid stays 0; en=1 -> out_valid=1, out_index=ptr value the next cycle.
REQ-032 reset_n pulsed low mid-cycle while out_valid=1 and index=7 -> out_valid=0 and out_index=0 immediately, without waiting for a clock edge; after release with req=0x80, out_index=7 and ptr restarts at 0.
REQ-033 Macro undefined, req=0x0000_0006, out_ready=1 -> out_index=1 every cycle; grant=0x2.
